// File: rtl/sa_weight_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sa_weight_load_ctrl: fetches a 3x3 weight tile column-major, feeds array.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sa_weight_load_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic [3:0]        w_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;

  logic                s1_vld_q;
  logic [3:0]          s1_idx_q;
  logic                wv_q;
  logic [DATA_W-1:0]   wd_q;
  logic [3:0]          wi_q;

  logic                issue;
  logic                abort_eff;
  logic [3:0]          map_off;

  assign issue     = (state_q == S_ISSUE);
  assign abort_eff = abort && (state_q != S_IDLE);

  // Row-major tile walked column by column.
  always_comb begin
    map_off = 4'd0;
    case (cnt_q)
      4'd0:    map_off = 4'd0;
      4'd1:    map_off = 4'd3;
      4'd2:    map_off = 4'd6;
      4'd3:    map_off = 4'd1;
      4'd4:    map_off = 4'd4;
      4'd5:    map_off = 4'd7;
      4'd6:    map_off = 4'd2;
      4'd7:    map_off = 4'd5;
      4'd8:    map_off = 4'd8;
      default: map_off = 4'd0;
    endcase
  end

  assign mem_rd_en = issue;
  assign mem_addr  = issue ? (base_q + ADDR_W'(map_off)) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    if (abort_eff) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_ISSUE;
            cnt_d   = 4'd0;
            base_d  = base_addr;
          end
        end
        S_ISSUE: begin
          if (cnt_q == 4'd8) begin
            state_d = S_DRAIN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == 4'd1) begin
            state_d = S_DONE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Two-stage read pipeline; data only captured for live reads so w_data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_idx_q <= 4'd0;
      wv_q     <= 1'b0;
      wd_q     <= '0;
      wi_q     <= 4'd0;
    end else if (abort_eff) begin
      s1_vld_q <= 1'b0;
      wv_q     <= 1'b0;
    end else begin
      s1_vld_q <= issue;
      s1_idx_q <= cnt_q;
      wv_q     <= s1_vld_q;
      if (s1_vld_q) begin
        wd_q <= mem_rdata;
        wi_q <= s1_idx_q;
      end
    end
  end

  assign w_valid = wv_q;
  assign w_data  = wd_q;
  assign w_idx   = wi_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sa_weight_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sa_weight_load_ctrl: directed scoreboard bench for sa_weight_load_ctrl. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sa_weight_load_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] base_addr = 6'd0;
  logic       mem_rd_en;
  logic [5:0] mem_addr;
  logic [7:0] mem_rdata = 8'd0;
  logic       w_valid;
  logic [7:0] w_data;
  logic [3:0] w_idx;
  logic       busy;
  logic       done;

  sa_weight_load_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memory content: mem[a] = a + 16, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 8'(mem_addr) + 8'd16;
  end

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] i;
  } ent_t;

  ent_t       sb[$];
  int         nerr = 0;
  int         nchk = 0;
  logic [7:0] last_wd = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_load(input int base);
    ent_t e;
    int   a;
    for (int i = 0; i < 9; i++) begin
      a   = (base + (i % 3) * 3 + i / 3) % 64;
      e.d = 8'((a + 16) % 256);
      e.i = 4'(i);
      sb.push_back(e);
    end
  endtask

  task automatic check_cycle(input int c, input int k, input int a, input int base);
    bit   live;
    bit   e_rd, e_busy, e_done, e_wv;
    int   e_addr;
    ent_t e;
    live   = (c <= a);
    e_rd   = live && (k >= 1) && (k <= 9);
    e_busy = live && (k >= 1) && (k <= 12);
    e_done = live && (k == 12);
    e_wv   = live && (k >= 3) && (k <= 11);
    e_addr = e_rd ? (base + ((k - 1) % 3) * 3 + (k - 1) / 3) % 64 : 0;
    chk($sformatf("c%0d mem_rd_en", c), 32'(mem_rd_en), 32'(e_rd));
    chk($sformatf("c%0d mem_addr", c), 32'(mem_addr), 32'(e_addr));
    chk($sformatf("c%0d busy", c), 32'(busy), 32'(e_busy));
    chk($sformatf("c%0d done", c), 32'(done), 32'(e_done));
    chk($sformatf("c%0d w_valid", c), 32'(w_valid), 32'(e_wv));
    if (e_wv) begin
      chk($sformatf("c%0d sb_nonempty", c), 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("c%0d w_data", c), 32'(w_data), 32'(e.d));
        chk($sformatf("c%0d w_idx", c), 32'(w_idx), 32'(e.i));
        last_wd = e.d;
      end
    end else begin
      chk($sformatf("c%0d w_data_hold", c), 32'(w_data), 32'(last_wd));
    end
  endtask

  // Cycle 0 always carries a start; hold keeps start high for back-to-back loads.
  task automatic run_seg(input int ncyc, input int base, input int a,
                         input bit hold, input int x1, input int x2);
    int s;
    s = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (hold && c == s + 13) s = c;
      start     = (c == 0) || hold || (c == x1) || (c == x2);
      abort     = (c == a);
      base_addr = 6'(base);
      if (c == s) push_load(base);
      @(negedge clk);
      check_cycle(c, c - s, a, base);
      if (c == a) sb.delete();
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " w_valid"}, 32'(w_valid), 32'd0);
    chk({tag, " w_data"}, 32'(w_data), 32'd0);
    chk({tag, " w_idx"}, 32'(w_idx), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // start together with abort in IDLE must not launch a load
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort busy", 32'(busy), 32'd0);
    chk("start_abort mem_rd_en", 32'(mem_rd_en), 32'd0);
    @(posedge clk);
    #1;

    // Test 1: base 0, full load
    run_seg(14, 0, 1000, 1'b0, -1, -1);
    chk("t1 sb_drained", 32'(sb.size()), 32'd0);

    // Test 2: base 60 wraps modulo 64
    run_seg(14, 60, 1000, 1'b0, -1, -1);
    chk("t2 sb_drained", 32'(sb.size()), 32'd0);

    // Test 3: abort in cycle 5
    run_seg(14, 5, 5, 1'b0, -1, -1);

    // Test 4: extra starts in cycles 4 and 12 ignored
    run_seg(16, 9, 1000, 1'b0, 4, 12);
    chk("t4 sb_drained", 32'(sb.size()), 32'd0);

    // Test 5: start held high -> loads from cycles 0 and 13
    run_seg(26, 20, 1000, 1'b1, -1, -1);
    chk("t5 sb_drained", 32'(sb.size()), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("t5 idle after", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
    end

    // Test 6: reset asserted in cycle 6 of a load
    run_seg(6, 0, 1000, 1'b0, -1, -1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    last_wd = 8'd0;
    @(posedge clk);
    #1;
    chk("midrst held busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    run_seg(14, 0, 1000, 1'b0, -1, -1);
    chk("t6 sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
